// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO, fixed-latency busy window,
// accumulate ops, register moves and flush/cancel support.
module md_unit #(
    parameter int DATA_W   = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic              cancel,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] out
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;
    localparam logic [3:0] OP_MFHI  = 4'd10;
    localparam logic [3:0] OP_MFLO  = 4'd11;

    localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE_W  = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic [DATA_W-1:0]   sh_hi_r;
    logic [DATA_W-1:0]   sh_lo_r;
    logic                sh_wr_r;

    logic                accept_s;
    logic                is_arith_s;
    logic                is_div_s;
    logic [CNT_W-1:0]    lat_s;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                commit_s;
    logic [2*DATA_W-1:0] opa_s;
    logic [2*DATA_W-1:0] opb_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] acc_s;
    logic [2*DATA_W-1:0] res_s;
    logic                neg_a_s;
    logic                neg_b_s;
    logic [DATA_W-1:0]   abs_a_s;
    logic [DATA_W-1:0]   abs_b_s;
    logic [DATA_W-1:0]   div_b_s;
    logic [DATA_W-1:0]   uq_s;
    logic [DATA_W-1:0]   ur_s;
    logic [DATA_W-1:0]   q_s;
    logic [DATA_W-1:0]   r_s;

    // Op decode: arithmetic class and its busy latency
    always_comb begin
        is_arith_s = 1'b0;
        is_div_s   = 1'b0;
        lat_s      = CNT_ZERO;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                is_arith_s = 1'b1;
                lat_s      = MULT_CNT;
            end
            OP_DIV, OP_DIVU: begin
                is_arith_s = 1'b1;
                is_div_s   = 1'b1;
                lat_s      = DIV_CNT;
            end
            default: begin
                is_arith_s = 1'b0;
                is_div_s   = 1'b0;
                lat_s      = CNT_ZERO;
            end
        endcase
    end

    // Multiply datapath; even op codes are the signed variants
    always_comb begin
        opa_s = {ZERO_W, rs};
        opb_s = {ZERO_W, rt};
        if (!op[0]) begin
            opa_s = {{DATA_W{rs[DATA_W-1]}}, rs};
            opb_s = {{DATA_W{rt[DATA_W-1]}}, rt};
        end else begin
            opa_s = {ZERO_W, rs};
            opb_s = {ZERO_W, rt};
        end
        prod_s = opa_s * opb_s;
        acc_s  = {hi_r, lo_r};
    end

    // Divide datapath on magnitudes; signs restored afterwards.
    // The most-negative / -1 case wraps naturally through the negation.
    always_comb begin
        neg_a_s = (op == OP_DIV) & rs[DATA_W-1];
        neg_b_s = (op == OP_DIV) & rt[DATA_W-1];
        abs_a_s = neg_a_s ? -rs : rs;
        abs_b_s = neg_b_s ? -rt : rt;
        if (rt == ZERO_W) begin
            div_b_s = ONE_W;
        end else begin
            div_b_s = abs_b_s;
        end
        uq_s = abs_a_s / div_b_s;
        ur_s = abs_a_s % div_b_s;
        q_s  = (neg_a_s ^ neg_b_s) ? -uq_s : uq_s;
        r_s  = neg_a_s ? -ur_s : ur_s;
    end

    // Result select for the shadow registers
    always_comb begin
        res_s = {2*DATA_W{1'b0}};
        case (op)
            OP_MULT, OP_MULTU: res_s = prod_s;
            OP_MADD, OP_MADDU: res_s = acc_s + prod_s;
            OP_MSUB, OP_MSUBU: res_s = acc_s - prod_s;
            OP_DIV,  OP_DIVU:  res_s = {r_s, q_s};
            default:           res_s = {2*DATA_W{1'b0}};
        endcase
    end

    // Busy counter next state; cancel wins over both countdown and issue
    always_comb begin
        accept_s  = start & ~cancel & (cnt_r == CNT_ZERO);
        commit_s  = (cnt_r == CNT_ONE) & ~cancel & sh_wr_r;
        cnt_nxt_s = CNT_ZERO;
        if (cancel) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (accept_s && is_arith_s) begin
            cnt_nxt_s = lat_s;
        end else begin
            cnt_nxt_s = CNT_ZERO;
        end
    end

    // Architectural and shadow state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            hi_r    <= ZERO_W;
            lo_r    <= ZERO_W;
            sh_hi_r <= ZERO_W;
            sh_lo_r <= ZERO_W;
            sh_wr_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            busy_r <= (cnt_nxt_s != CNT_ZERO);
            if (cancel) begin
                sh_hi_r <= ZERO_W;
                sh_lo_r <= ZERO_W;
                sh_wr_r <= 1'b0;
            end else if (accept_s && is_arith_s) begin
                sh_hi_r <= res_s[2*DATA_W-1:DATA_W];
                sh_lo_r <= res_s[DATA_W-1:0];
                // divide by zero burns the latency but never writes HI/LO
                sh_wr_r <= ~(is_div_s & (rt == ZERO_W));
            end
            if (commit_s) begin
                hi_r <= sh_hi_r;
                lo_r <= sh_lo_r;
            end else if (accept_s && (op == OP_MTHI)) begin
                hi_r <= rs;
            end else if (accept_s && (op == OP_MTLO)) begin
                lo_r <= rs;
            end
        end
    end

    // Move-from read port, independent of start and busy
    always_comb begin
        case (op)
            OP_MFHI: out = hi_r;
            OP_MFLO: out = lo_r;
            default: out = ZERO_W;
        endcase
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit (DATA_W=32, MULT_LAT=5, DIV_LAT=10).
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    int checks   = 0;
    int failures = 0;

    md_unit #(.DATA_W(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; presents the op for one edge and returns at the next negedge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
        op    = 4'd12;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic set_hl(input logic [31:0] h, input logic [31:0] l);
        issue(4'd8, h, 32'h0);
        issue(4'd9, l, 32'h0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{4'd0, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{4'd1, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{4'd3, 32'h7, 32'h2, 32'h0, 32'h0, 32'h1, 32'h3, 10};
        vecs[3]  = '{4'd2, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h0, 32'h80000000, 10};
        vecs[5]  = '{4'd3, 32'h5, 32'h0, 32'h11, 32'h22, 32'h11, 32'h22, 10};
        vecs[6]  = '{4'd5, 32'h1, 32'h1, 32'h1, 32'hFFFFFFFF, 32'h2, 32'h0, 5};
        vecs[7]  = '{4'd6, 32'h2, 32'h3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[8]  = '{4'd4, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h10, 32'h0, 32'hE, 5};
        vecs[9]  = '{4'd7, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h2, 5};
        vecs[10] = '{4'd2, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFD, 10};

        reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 4'd10; rs = 32'h0; rt = 32'h0;
        #12;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_out", out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        op = 4'd12;

        for (int i = 0; i < 11; i++) begin
            set_hl(vecs[i].pre_hi, vecs[i].pre_lo);
            chk($sformatf("v%0d_pre_hi", i), hi, vecs[i].pre_hi);
            chk($sformatf("v%0d_pre_lo", i), lo, vecs[i].pre_lo);
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_idle(n);
            chk($sformatf("v%0d_lat", i), n, vecs[i].lat);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // Combinational move-from port
        set_hl(32'hAB, 32'hCD);
        op = 4'd10; #1 chk("mfhi_out", out, 32'hAB);
        op = 4'd11; #1 chk("mflo_out", out, 32'hCD);
        op = 4'd12; #1 chk("nop_out", out, 32'h0);
        op = 4'd0;  #1 chk("mult_out", out, 32'h0);
        op = 4'd12;
        @(negedge clk);

        // Cancel in busy cycle 3
        set_hl(32'h5, 32'h6);
        issue(4'd0, 32'h3, 32'h4);
        @(negedge clk); @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_mid_busy", {31'h0, busy}, 32'h0);
        repeat (6) @(negedge clk);
        chk("cancel_mid_hi", hi, 32'h5);
        chk("cancel_mid_lo", lo, 32'h6);

        // Cancel on the final busy cycle beats the commit
        issue(4'd1, 32'h3, 32'h4);
        repeat (4) @(negedge clk);
        chk("cancel_last_busy_before", {31'h0, busy}, 32'h1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_last_busy", {31'h0, busy}, 32'h0);
        chk("cancel_last_hi", hi, 32'h5);
        chk("cancel_last_lo", lo, 32'h6);

        // start together with cancel accepts nothing
        cancel = 1'b1;
        issue(4'd9, 32'h99, 32'h0);
        chk("start_cancel_mtlo", lo, 32'h6);
        issue(4'd0, 32'h2, 32'h2);
        cancel = 1'b0;
        chk("start_cancel_mult_busy", {31'h0, busy}, 32'h0);

        // start while busy is ignored
        set_hl(32'h0, 32'h0);
        issue(4'd3, 32'h9, 32'h4);
        issue(4'd9, 32'h77, 32'h0);
        issue(4'd0, 32'h5, 32'h5);
        wait_idle(n);
        chk("busy_ignore_lat", n, 32'd8);
        chk("busy_ignore_hi", hi, 32'h1);
        chk("busy_ignore_lo", lo, 32'h2);

        // Back-to-back issue right after busy falls
        issue(4'd1, 32'h2, 32'h3);
        wait_idle(n);
        chk("b2b_first_lo", lo, 32'h6);
        issue(4'd1, 32'h4, 32'h5);
        chk("b2b_second_busy", {31'h0, busy}, 32'h1);
        wait_idle(n);
        chk("b2b_second_lat", n, 32'd5);
        chk("b2b_second_lo", lo, 32'h14);

        // Asynchronous reset mid-divide
        set_hl(32'h11, 32'h22);
        issue(4'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        op = 4'd10;
        #1;
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        chk("rst_mid_out", out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        op = 4'd12;
        repeat (12) @(negedge clk);
        chk("rst_after_busy", {31'h0, busy}, 32'h0);
        chk("rst_after_hi", hi, 32'h0);
        chk("rst_after_lo", lo, 32'h0);
        issue(4'd9, 32'h42, 32'h0);
        chk("rst_resume_lo", lo, 32'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
